// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared period counter, edge- or center-aligned counting,
// and double-buffered period/duty registers that load together at the period boundary.
module pwm_multi #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 16,
  parameter int SEL_WIDTH = 5
) (
  input  logic                 refClock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 centerMode,
  input  logic                 wrEn,
  input  logic [SEL_WIDTH-1:0] wrSel,
  input  logic [CNT_WIDTH-1:0] wrData,
  output logic [CHANNELS-1:0]  pwmOut,
  output logic                 updateEvent,
  output logic [CNT_WIDTH-1:0] counterOut
);

  logic [CNT_WIDTH-1:0] counter;
  logic [CNT_WIDTH-1:0] period_sh;
  logic [CNT_WIDTH-1:0] period_act;
  logic [CNT_WIDTH-1:0] duty_sh  [CHANNELS];
  logic [CNT_WIDTH-1:0] duty_act [CHANNELS];
  logic                 dir_down;
  logic                 mode_act;
  logic                 center_eff;
  logic                 terminal;
  logic [CHANNELS-1:0]  cmp;

  // A zero period in center mode degenerates to edge behaviour.
  always_comb begin
    center_eff = mode_act && (period_act != '0);
  end

  // With P == 1 the single up-count cycle at the top is also the last cycle of the period.
  always_comb begin
    if (center_eff) begin
      terminal = (counter == CNT_WIDTH'(1)) && (dir_down || (counter == period_act));
    end else begin
      terminal = (counter == period_act);
    end
  end

  always_comb begin
    cmp = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cmp[i] = (counter < duty_act[i]);
    end
  end

  always_ff @(posedge refClock) begin
    if (reset) begin
      period_sh <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh[i] <= '0;
      end
    end else if (wrEn) begin
      if (wrSel == '0) begin
        period_sh <= wrData;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (wrSel == SEL_WIDTH'(i + 1)) begin
          duty_sh[i] <= wrData;
        end
      end
    end
  end

  // Active registers take the pre-write shadow values, so a write on the update edge waits a period.
  always_ff @(posedge refClock) begin
    if (reset) begin
      counter     <= '0;
      dir_down    <= 1'b0;
      period_act  <= '0;
      mode_act    <= 1'b0;
      pwmOut      <= '0;
      updateEvent <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_act[i] <= '0;
      end
    end else if (!enable) begin
      counter     <= '0;
      dir_down    <= 1'b0;
      period_act  <= period_sh;
      mode_act    <= centerMode;
      pwmOut      <= '0;
      updateEvent <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_act[i] <= duty_sh[i];
      end
    end else begin
      pwmOut <= cmp;
      if (terminal) begin
        counter     <= '0;
        dir_down    <= 1'b0;
        period_act  <= period_sh;
        mode_act    <= centerMode;
        updateEvent <= 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
          duty_act[i] <= duty_sh[i];
        end
      end else begin
        updateEvent <= 1'b0;
        if (center_eff && dir_down) begin
          counter <= counter - CNT_WIDTH'(1);
        end else if (center_eff && (counter == period_act)) begin
          dir_down <= 1'b1;
          counter  <= counter - CNT_WIDTH'(1);
        end else begin
          counter <= counter + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign counterOut = counter;

endmodule

// File: tb/tb_pwm_multi.sv
// Randomised and directed bench for pwm_multi; a phase-based reference model feeds a
// scoreboard queue that a monitor drains on every falling edge.
module tb_pwm_multi;

  localparam int CH = 4;
  localparam int CW = 8;
  localparam int SW = 5;

  logic          refClock;
  logic          reset;
  logic          enable;
  logic          centerMode;
  logic          wrEn;
  logic [SW-1:0] wrSel;
  logic [CW-1:0] wrData;
  logic [CH-1:0] pwmOut;
  logic          updateEvent;
  logic [CW-1:0] counterOut;

  typedef struct {
    int            cnt;
    logic [CH-1:0] pwm;
    logic          upd;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position inside the period is a phase index, not a counter/direction pair.
  int   shP = 0;
  int   actP = 0;
  int   shD[CH] = '{default: 0};
  int   actD[CH] = '{default: 0};
  bit   actC = 0;
  int   phase = 0;

  pwm_multi #(.CHANNELS(CH), .CNT_WIDTH(CW), .SEL_WIDTH(SW)) dut (
    .refClock(refClock),
    .reset(reset),
    .enable(enable),
    .centerMode(centerMode),
    .wrEn(wrEn),
    .wrSel(wrSel),
    .wrData(wrData),
    .pwmOut(pwmOut),
    .updateEvent(updateEvent),
    .counterOut(counterOut)
  );

  initial begin
    refClock = 1'b0;
    forever #5 refClock = ~refClock;
  end

  function automatic int periodLen(input int p, input bit c);
    return (c && p > 0) ? 2 * p : p + 1;
  endfunction

  function automatic int countAt(input int ph, input int p, input bit c);
    if (c && p > 0) return (ph <= p) ? ph : 2 * p - ph;
    return ph;
  endfunction

  task automatic modelEdge(output exp_t e);
    int nshP;
    int nshD[CH];
    int cnt;
    e.pwm = '0;
    e.upd = 1'b0;
    if (reset) begin
      shP = 0; actP = 0; actC = 0; phase = 0;
      shD = '{default: 0};
      actD = '{default: 0};
    end else begin
      nshP = shP;
      nshD = shD;
      if (wrEn) begin
        if (wrSel == 0) nshP = int'(wrData);
        else if (int'(wrSel) <= CH) nshD[int'(wrSel) - 1] = int'(wrData);
      end
      if (!enable) begin
        actP = shP; actD = shD; actC = centerMode; phase = 0;
      end else begin
        cnt = countAt(phase, actP, actC);
        for (int i = 0; i < CH; i++) e.pwm[i] = (cnt < actD[i]);
        if (phase == periodLen(actP, actC) - 1) begin
          actP = shP; actD = shD; actC = centerMode; phase = 0;
          e.upd = 1'b1;
        end else begin
          phase++;
        end
      end
      shP = nshP;
      shD = nshD;
    end
    e.cnt = countAt(phase, actP, actC);
  endtask

  // One clock: predict, let the edge happen, queue the prediction, return at the falling edge.
  task automatic applyStimulus();
    exp_t e;
    modelEdge(e);
    @(posedge refClock);
    expQ.push_back(e);
    @(negedge refClock);
    wrEn = 1'b0;
  endtask

  task automatic writeReg(input int sel, input int data);
    wrEn = 1'b1;
    wrSel = SW'(sel);
    wrData = CW'(data);
    applyStimulus();
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  task automatic runUntilPhase(input int ph);
    for (int k = 0; k < 600 && phase != ph; k++) applyStimulus();
  endtask

  task automatic checkOutput(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Counts how many of the next n cycles show the chosen output high (ch < 0 selects updateEvent).
  task automatic checkHighCount(input string name, input int ch, input int n, input int want);
    int hi;
    hi = 0;
    for (int k = 0; k < n; k++) begin
      applyStimulus();
      if (ch < 0) hi += int'(updateEvent);
      else hi += int'(pwmOut[ch]);
    end
    checkOutput(name, hi, want);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge refClock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("counterOut", int'(counterOut), e.cnt);
        checkOutput("pwmOut", int'(pwmOut), int'(e.pwm));
        checkOutput("updateEvent", int'(updateEvent), int'(e.upd));
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1; enable = 1'b0; centerMode = 1'b0;
    wrEn = 1'b0; wrSel = '0; wrData = '0;
    runCycles(2);
    reset = 1'b0;

    // Edge mode, P=9, duty0=3.
    writeReg(0, 9);
    writeReg(1, 3);
    runCycles(1);
    enable = 1'b1;
    runCycles(20);
    checkHighCount("edge_duty3_high", 0, 10, 3);
    checkHighCount("edge_update_rate", -1, 10, 1);

    // Mid-period duty change, then a write landing on the update edge.
    runUntilPhase(4);
    writeReg(1, 7);
    runCycles(12);
    runUntilPhase(9);
    writeReg(1, 2);
    runCycles(22);

    // Center mode, P=5, duty1=2.
    centerMode = 1'b1;
    writeReg(0, 5);
    writeReg(2, 2);
    runCycles(30);
    checkHighCount("center_duty2_high", 1, 10, 3);
    checkHighCount("center_update_rate", -1, 10, 1);

    // Boundaries: duty 0, duty above period, zero period, invalid select.
    centerMode = 1'b0;
    writeReg(0, 9);
    writeReg(3, 0);
    writeReg(4, 10);
    runCycles(25);
    checkHighCount("duty0_const_low", 2, 10, 0);
    checkHighCount("duty_gt_p_const_high", 3, 10, 10);
    writeReg(0, 0);
    writeReg(1, 1);
    runCycles(15);
    checkHighCount("p0_pwm_const_high", 0, 5, 5);
    checkHighCount("p0_update_held", -1, 5, 5);
    writeReg(7, 255);
    runCycles(5);

    // Disable mid-period, reprogram while disabled, re-enable.
    writeReg(0, 9);
    runCycles(25);
    runUntilPhase(5);
    enable = 1'b0;
    applyStimulus();
    writeReg(0, 3);
    runCycles(1);
    enable = 1'b1;
    runCycles(4);
    checkHighCount("p3_update_rate", -1, 8, 2);

    // Reset mid-period with all channels high, then run without writes.
    writeReg(0, 9);
    for (int i = 1; i <= CH; i++) writeReg(i, 9);
    runCycles(25);
    runUntilPhase(6);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    runCycles(5);
    checkHighCount("post_reset_pwm_low", 0, 10, 0);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 49) == 0) centerMode = ~centerMode;
      wrEn = ($urandom_range(0, 7) == 0);
      wrSel = SW'($urandom_range(0, 7));
      wrData = CW'($urandom_range(0, 12));
      modelAndStep();
    end
    reset = 1'b0;
    runCycles(2);
    @(negedge refClock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Random writes are driven directly so applyStimulus keeps the strobe for this cycle only.
  task automatic modelAndStep();
    applyStimulus();
  endtask

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator, the parametrised successor of the single-channel PWM core. It provides CHANNELS outputs sharing one period counter, with edge-aligned or center-aligned counting. Period and duty values are double-buffered: writes go to shadow registers and take effect together at the period boundary. It sits behind the PLL-generated clock and is driven by a simple write port from the controller.

Parameters:
CHANNELS, 4, number of PWM outputs (1..16)
CNT_WIDTH, 16, width of the counter, period and duty registers
SEL_WIDTH, 5, width of the write select field; must satisfy 2^SEL_WIDTH > CHANNELS

Ports:
refClock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = run counter; 0 = hold counter at 0, outputs low
centerMode  input  1  0 = edge-aligned, 1 = center-aligned; sampled at update
wrEn  input  1  write strobe, one write per cycle
wrSel  input  SEL_WIDTH  0 = period shadow; k (1..CHANNELS) = duty shadow of channel k-1; other values ignored
wrData  input  CNT_WIDTH  write value
pwmOut  output  CHANNELS  PWM outputs, registered
updateEvent  output  1  one-cycle pulse when shadow values load into active registers
counterOut  output  CNT_WIDTH  current counter value, for debug and test

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - counter, shadow and active period, all shadow and active duties: 0.
  - direction: up. Active mode: edge.
  - pwmOut = 0, updateEvent = 0.
- Shadow writes:
  - When wrEn=1 and wrSel is valid, the shadow register updates at the clock edge.
  - An invalid wrSel is a no-op.
  - Writes are allowed in every state, including enable=0.
- enable=0:
  - counter = 0, direction up, pwmOut = 0, updateEvent = 0.
  - Active registers copy the shadow registers and centerMode every cycle, so the first period after enable rises uses the current shadow values.
- Edge mode:
  - counter runs 0,1,...,P and then wraps to 0, where P is the active period. Period length is P+1 cycles.
  - Terminal cycle: counter == P.
- Center mode:
  - counter runs 0 up to P, then down to 1, then back to 0. Direction reverses at P. Period length is 2P cycles.
  - Terminal cycle: direction down and counter == 1.
  - If P == 0, the block behaves as edge mode.
- Update:
  - On the clock edge that ends the terminal cycle: counter becomes 0, direction becomes up, active period/duties/mode load from shadow/centerMode, and updateEvent = 1 for exactly the next cycle.
  - A shadow write in the same cycle as the update edge is not loaded. The pre-write value loads, and the new value takes effect at the following update.
- Output compare:
  - pwmOut[i] is registered from (counter < activeDuty[i]), so it lags counter by 1 cycle.
  - Duty 0 gives a constant 0.
  - In edge mode, duty > P gives a constant 1. In center mode, duty > P also gives a constant 1.
  - Center-mode high time = 2*duty - 1 cycles per period for 0 < duty <= P.
- P == 0 in edge mode:
  - counter stays 0 and an update occurs every cycle, so updateEvent stays high continuously.
  - pwmOut[i] = 1 iff duty >= 1.
- Unsigned arithmetic throughout, no overflow possible: the counter never exceeds P, which is at most 2^CNT_WIDTH - 1.
- Reset mid-period: takes effect at the next edge, returning to the reset values immediately. No partial period is completed.
- Write-port latency: a write is visible in shadow 1 cycle later. It is visible on pwmOut no earlier than the end of the current period plus 1 cycle.

Test Plan:
1. CNT_WIDTH=8. Reset, write P=9 and duty0=3, then enable=1 in edge mode -> counterOut cycles 0..9. pwmOut[0] is high 3 of every 10 cycles, lagging counter by 1. updateEvent pulses once every 10 cycles.
2. Running with P=9 and duty0=3, write duty0=7 at counter=4 -> the current period still shows high=3. From the next period, high=7. The write lands exactly on the update edge -> the new value appears one period later.
3. centerMode=1, P=5, duty1=2 -> counter 0,1,2,3,4,5,4,3,2,1 repeating (10 cycles). pwmOut[1] is high for 3 consecutive cycles per period. updateEvent pulses when the counter returns to 0.
4. Boundaries: duty2=0 -> constant 0. duty3=10 with P=9 -> constant 1. P=0, duty0=1 -> pwmOut[0] constant 1 and updateEvent held high. wrSel=7 with CHANNELS=4 -> no register changes.
5. enable=0 mid-period -> next cycle counter=0 and pwmOut=0. Write P=3 while disabled, then re-enable -> the first period is 4 cycles.
6. Assert reset at counter=6 with all channels high -> next cycle all outputs, counter and updateEvent are 0. All shadow and active registers are 0, verified by enabling without writes: outputs stay 0.
